regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the MIPS datapath, successor to the single-write/dual-read file. Provides NUM_RD registered read ports, two write ports with defined collision priority, write-first bypass, optional hardwired-zero register 0, and a self-clearing reset sequencer. The sequencer lets the storage map onto RAM-style arrays without a parallel clear. Sits between the decode stage (read addresses) and the writeback stage (ALU and load writeback ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset; restarts the clear sequence
- ready  out  1  high when the file is cleared and accepting writes
- we0  in  1  write enable, port 0 (ALU writeback)
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (load writeback)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- ra  in  NUM_RD*ADDR_W  read addresses; port i = ra[i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  registered read data, same packing

## Operation
- FSM states: CLEAR, RUN.
- rst high at an edge: state <= CLEAR, cnt <= 0, ready <= 0, all rdata <= 0. Applies from any state, including mid-clear.
- CLEAR, rst low: each edge writes mem[cnt] <= 0, cnt <= cnt+1. On the edge where cnt == DEPTH-1: state <= RUN, ready <= 1.
- CLEAR also forces:
  - we0/we1 ignored;
  - rdata driven to 0 each edge.
- RUN, writes:
  - we0 writes wd0 to wa0; we1 writes wd1 to wa1.
  - Both enabled with wa0 == wa1: port 1 wins and port 0 is dropped.
  - ZERO_REG=1: writes to address 0 are dropped.
- RUN, reads: for each port i, rdata_i <= value of mem[ra_i] after this edge's writes are applied (write-first bypass). Precedence: matching we1 data, else matching we0 data, else stored value.
- ZERO_REG=1 and ra_i == 0: rdata_i <= 0 regardless of bypass.
- No arithmetic; the cnt width is ADDR_W and it never wraps, because the FSM leaves CLEAR at DEPTH-1.

## Timing
- Read latency is 1 cycle: ra sampled at edge N appears on rdata after edge N, including data written at edge N.
- Write latency: data is visible to a read sampled at the same edge (bypass) and to all later reads.
- Reset values: ready=0, rdata=0, state=CLEAR, cnt=0.
- ready rises exactly DEPTH edges after the first edge with rst low (32 for defaults).
- rst asserted during RUN: contents are not preserved logically. The file is fully re-cleared before ready returns high.
- ra/we inputs are don't-care while ready=0.

## Structure
- Package regfile_pkg holds:
  - state enum (CLEAR, RUN);
  - default parameter constants;
  - function for DEPTH from ADDR_W.
- Sub-module regfile_rd_port: one read port containing the bypass compare, zero-register mask and output register. Instantiated NUM_RD times via generate.
- The top level holds the storage array, the write-collision logic and the FSM/counter.

## Test plan
- Reset: rst high 2 cycles then low → ready=0 for 32 edges, 1 on the 32nd; reads of all 32 addresses return 0.
- Basic write/read: we0, wa0=5, wd0=0xDEADBEEF; next cycle ra0=5 → rdata0=0xDEADBEEF one edge later.
- Bypass: same edge we1, wa1=7, wd1=0x12345678 with ra1=7 → rdata1=0x12345678 after that edge.
- Collision: we0/we1 both to address 9, wd0=0x1, wd1=0x2 → read of 9 returns 0x2, both via bypass and one cycle later.
- Zero register: we0 wa0=0 wd0=0xFFFFFFFF with ra0=0 → rdata0=0 that cycle and afterwards. With ZERO_REG=0 the same stimulus → 0xFFFFFFFF.
- Reset mid-operation: write 0xAA to address 3, assert rst during RUN and again 10 edges into CLEAR. Required response:
  - ready stays 0 until 32 edges after the final deassert;
  - read of address 3 then returns 0;
  - writes issued during CLEAR leave no effect.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port MIPS register file.
// DEPTH is always derived from the address width through depth_of().
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port with write-first bypass and the register-0 mask.
// Port 1 data takes precedence over port 0 data because port 1 wins collisions.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] rdata
);

    logic zero_hit;

    assign zero_hit = (ZERO_REG != 0) && (ra == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rdata <= '0;
        end else if (zero_hit) begin
            rdata <= '0;
        end else if (wr1 && (wa1 == ra)) begin
            rdata <= wd1;
        end else if (wr0 && (wa0 == ra)) begin
            rdata <= wd0;
        end else begin
            rdata <= mem_data;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, write-collision resolution and the clear sequencer.
// ready is high once the clear sweep has finished; writes and reads presented while it is low are ignored.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int                DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   cnt, cnt_n;
    logic                ready_n;
    logic                clr_we;
    logic                run;
    logic                wr0, wr1;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign run = (state == RUN);

    // Port 0 is dropped when port 1 targets the same address in the same cycle.
    assign wr0 = run && we0 && !(we1 && (wa1 == wa0)) && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1 = run && we1 && !((ZERO_REG != 0) && (wa1 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ready <= ready_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ready_n = ready;
        clr_we  = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt == LAST) begin
                    state_n = RUN;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
                state_n = CLEAR;
            end
        endcase
    end

    // The sweep clears one entry per cycle so the array maps onto RAM without a parallel clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[cnt] <= '0;
            end else begin
                if (wr0) mem[wa0] <= wd0;
                if (wr1) mem[wa1] <= wd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_i;
        assign ra_i = ra[i*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .clear    (!run),
            .ra       (ra_i),
            .mem_data (mem[ra_i]),
            .wr0      (wr0),
            .wa0      (wa0),
            .wd0      (wd0),
            .wr1      (wr1),
            .wa1      (wa1),
            .wd1      (wd1),
            .rdata    (rdata[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a ZERO_REG=1 instance plus a ZERO_REG=0 twin on the same stimulus.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [AW-1:0] ra0, ra1;
    logic          ready, ready_nz;
    logic [NR*DW-1:0] rdata, rdata_nz;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra({ra1, ra0}), .rdata(rdata)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .ready(ready_nz),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra({ra1, ra0}), .rdata(rdata_nz)
    );

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [DW-1:0] enz;
    } vec_t;

    int            total  = 0;
    int            passed = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model[32];
    vec_t          vt[10];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs are already driven; push expectations, take one edge, compare.
    task automatic read_cycle(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic chk_nz, input logic [DW-1:0] enz);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        if (chk_nz) exp_q.push_back(enz);
        step();
        check({tag, "_rd0"}, rdata[DW-1:0], exp_q.pop_front());
        check({tag, "_rd1"}, rdata[2*DW-1:DW], exp_q.pop_front());
        if (chk_nz) check({tag, "_nz_rd0"}, rdata_nz[DW-1:0], exp_q.pop_front());
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return model[a];
    endfunction

    task automatic model_update();
        if (we0 && wa0 != '0 && !(we1 && wa1 == wa0)) model[wa0] = wd0;
        if (we1 && wa1 != '0) model[wa1] = wd1;
    endtask

    initial begin
        rst = 1'b1; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0;
        wd0 = '0; wd1 = '0; ra0 = '0; ra1 = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        vt[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vt[2] = '{1'b1, 5'd9,  32'h00000001, 1'b1, 5'd9,  32'h00000002, 5'd9,  5'd5,  32'h00000002, 32'hDEADBEEF, 32'h00000002};
        vt[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  32'h00000002, 32'h12345678, 32'h00000002};
        vt[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'hFFFFFFFF};
        vt[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd9,  32'h0,        32'h00000002, 32'hFFFFFFFF};
        vt[6] = '{1'b1, 5'd12, 32'hA5A5A5A5, 1'b1, 5'd13, 32'h5A5A5A5A, 5'd13, 5'd12, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A};
        vt[7] = '{1'b1, 5'd31, 32'h11112222, 1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'h11112222, 32'hDEADBEEF, 32'h11112222};
        vt[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h77777777, 5'd0,  5'd31, 32'h0,        32'h11112222, 32'h77777777};
        vt[9] = '{1'b1, 5'd5,  32'h0BADF00D, 1'b0, 5'd0,  32'h0,        5'd5,  5'd12, 32'h0BADF00D, 32'hA5A5A5A5, 32'h0BADF00D};

        // Reset held for two edges.
        step();
        step();
        check("reset_ready", {31'b0, ready}, 32'h0);
        check("reset_rd0", rdata[DW-1:0], 32'h0);
        check("reset_rd1", rdata[2*DW-1:DW], 32'h0);

        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            check("ready_rise", {31'b0, ready}, (k == 32) ? 32'h1 : 32'h0);
        end
        check("ready_rise_nz", {31'b0, ready_nz}, 32'h1);

        for (int a = 0; a < 32; a += 2) begin
            ra0 = AW'(a);
            ra1 = AW'(a + 1);
            read_cycle("cleared", 32'h0, 32'h0, 1'b1, 32'h0);
        end

        for (int v = 0; v < 10; v++) begin
            we0 = vt[v].we0; wa0 = vt[v].wa0; wd0 = vt[v].wd0;
            we1 = vt[v].we1; wa1 = vt[v].wa1; wd1 = vt[v].wd1;
            ra0 = vt[v].ra0; ra1 = vt[v].ra1;
            read_cycle($sformatf("vec%0d", v), vt[v].e0, vt[v].e1, 1'b1, vt[v].enz);
            model_update();
        end

        // Random traffic on a narrow address range to hit collisions and bypass often.
        for (int n = 0; n < 150; n++) begin
            we0 = 1'($urandom_range(0, 1)); wa0 = AW'($urandom_range(0, 7)); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = AW'($urandom_range(0, 7)); wd1 = $urandom;
            ra0 = AW'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            read_cycle("rand", exp_read(ra0), exp_read(ra1), 1'b0, 32'h0);
            model_update();
        end

        // Reset during RUN, then again ten edges into the clear.
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAA; we1 = 1'b0; ra0 = 5'd3; ra1 = 5'd0;
        read_cycle("pre_rst_byp", 32'hAA, 32'h0, 1'b0, 32'h0);
        we0 = 1'b0;
        read_cycle("pre_rst_rd", 32'hAA, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        check("rst_run_ready", {31'b0, ready}, 32'h0);
        rst = 1'b0;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h66;
        ra0 = 5'd3; ra1 = 5'd4;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("clear1_ready", {31'b0, ready}, 32'h0);
            check("clear1_rd0", rdata[DW-1:0], 32'h0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            check("clear2_ready", {31'b0, ready}, (k == 32) ? 32'h1 : 32'h0);
            check("clear2_rd1", rdata[2*DW-1:DW], 32'h0);
        end
        we0 = 1'b0; we1 = 1'b0;
        for (int a = 0; a < 32; a += 2) begin
            ra0 = AW'(a);
            ra1 = AW'(a + 1);
            read_cycle("recleared", 32'h0, 32'h0, 1'b0, 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
